if_prefetch_buffer: RTL and testbench

//  Instruction prefetch queue upstream of the IF/ID pipe register in the pipelined CPU.

---
 rtl/if_prefetch_buffer.sv | 145 ++++++++++++++
 tb/tb_if_prefetch_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue: fetches sequential words from a variable-latency
// memory (one request in flight) into a small FIFO that feeds the IF/ID register.
module if_prefetch_buffer #(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        PC_W     = 64,
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [PC_W-1:0]       redirect_pc_i,
    output logic                  mem_req_o,
    output logic [PC_W-1:0]       mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [PC_W-1:0]       instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t            state_reg, state_next;
    logic              stale_reg, stale_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PC_W-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [PC_W-1:0]   req_pc_reg, req_pc_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic              push, pop;

    logic [PC_W-1:0]   pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];

    assign mem_req_o     = (state_reg == ST_REQ);
    assign mem_addr_o    = req_pc_reg;
    assign instr_valid_o = (count_reg != '0);
    assign instr_o       = instr_mem[rd_ptr_reg];
    assign instr_pc_o    = pc_mem[rd_ptr_reg];

    always_comb begin
        state_next    = state_reg;
        stale_next    = stale_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        push          = 1'b0;
        pop           = instr_valid_o & instr_ready_i & ~redirect_i;

        if (redirect_i) begin
            fetch_pc_next = redirect_pc_i;
        end

        case (state_reg)
            ST_IDLE: begin
                if (redirect_i || (count_reg < DEPTH_C)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    stale_next = 1'b1;
                end
                if (mem_ready_i) begin
                    state_next = ST_WAIT;
                    // A request already made stale must not advance the redirected PC.
                    if (!redirect_i && !stale_reg) begin
                        fetch_pc_next = fetch_pc_reg + PC_W'(4);
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    stale_next = 1'b0;
                    if (stale_reg || redirect_i) begin
                        state_next = ST_REQ;
                    end else begin
                        push = 1'b1;
                        if ((count_reg + CNT_W'(1) - CNT_W'(pop)) < DEPTH_C) begin
                            state_next = ST_REQ;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end else if (redirect_i) begin
                    stale_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The request address is captured only on entry so it holds until accepted.
        if ((state_next == ST_REQ) && (state_reg != ST_REQ)) begin
            req_pc_next = fetch_pc_next;
        end

        if (redirect_i) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            stale_reg    <= 1'b0;
            count_reg    <= '0;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            stale_reg    <= stale_next;
            count_reg    <= count_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
            if (redirect_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_reg]    <= req_pc_reg;
            instr_mem[wr_ptr_reg] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Scoreboard bench for if_prefetch_buffer: a memory model answers fetches, a
// monitor pops expected {pc, instr} entries whenever the buffer hands one over.
module tb_if_prefetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [63:0] exp_addr[$];

    // memory model controls
    logic        mem_stall = 1'b0;
    int          rvalid_delay = 0;
    logic        hold_en = 1'b0;
    logic [63:0] hold_addr = '0;
    logic        resp_pending = 1'b0;
    logic [63:0] resp_addr = '0;
    int          resp_wait = 0;
    int          acc_count = 0;

    exp_t        mon_e;
    logic [63:0] mem_ea;

    if_prefetch_buffer #(
        .DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .mem_req_o(mem_req),
        .mem_addr_o(mem_addr),
        .mem_ready_i(mem_ready),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata),
        .instr_valid_o(instr_valid),
        .instr_o(instr),
        .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] ^ 32'h5A5A_0F0F) + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic push_data(input logic [63:0] pc0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: pc0 + 64'(4 * i), instr: word_of(pc0 + 64'(4 * i))});
        end
    endtask

    task automatic push_addr(input logic [63:0] pc0, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(pc0 + 64'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_stall = 1'b0;
        rvalid_delay = 0;
        hold_en = 1'b0;
        repeat (3) tick();
        resp_pending = 1'b0;
        acc_count = 0;
        exp_q.delete();
        exp_addr.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_pending(input logic [63:0] a, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(resp_pending && resp_addr == a) && n < 200);
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s: request for %h not accepted within 200 cycles", nm, a);
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!mem_req) begin
            failures++;
            $display("FAIL %s: mem_req got 0 required 1 within 20 cycles", nm);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || exp_addr.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        instr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: outputs left %0d, requests left %0d, required 0/0",
                     nm, exp_q.size(), exp_addr.size());
        end
    endtask

    // Memory model: single outstanding request, rdata is a function of the address.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_pending && resp_wait == 0 && !(hold_en && resp_addr == hold_addr)) begin
                mem_rvalid   = 1'b1;
                mem_rdata    = word_of(resp_addr);
                resp_pending = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                if (resp_pending && resp_wait > 0) resp_wait--;
            end
            mem_ready = !mem_stall;
            if (mem_req && mem_ready) begin
                acc_count++;
                resp_pending = 1'b1;
                resp_addr    = mem_addr;
                resp_wait    = rvalid_delay;
                if (exp_addr.size() > 0) begin
                    mem_ea = exp_addr.pop_front();
                    checks++;
                    if (mem_addr !== mem_ea) begin
                        failures++;
                        $display("FAIL req_addr: got %h required %h", mem_addr, mem_ea);
                    end
                end
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready && !redirect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected: got pc=%h instr=%h required no output", instr_pc, instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (instr_pc !== mon_e.pc || instr !== mon_e.instr) begin
                        failures++;
                        $display("FAIL out_entry: got pc=%h instr=%h required pc=%h instr=%h",
                                 instr_pc, instr, mon_e.pc, mon_e.instr);
                    end else begin
                        $display("out pc=%h instr=%h", instr_pc, instr);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);

        // 1: streaming, zero-wait memory
        do_reset();
        instr_ready = 1'b1;
        push_addr(64'h0, 6);
        push_data(64'h0, 6);
        wait_req("t1_first_req");
        drain("t1");

        // 2: stalled consumer saturates the queue
        do_reset();
        push_addr(64'h0, 6);
        push_data(64'h0, 6);
        repeat (20) tick();
        chk("t2_mem_req_idle", 64'(mem_req), 64'd0);
        chk("t2_valid", 64'(instr_valid), 64'd1);
        chk("t2_head_pc", instr_pc, 64'h0);
        chk("t2_accepts", 64'(acc_count), 64'd4);
        instr_ready = 1'b1;
        drain("t2");

        // 3: redirect while waiting for PC 8
        do_reset();
        rvalid_delay = 3;
        instr_ready = 1'b1;
        push_addr(64'h0, 3);
        push_data(64'h0, 2);
        wait_pending(64'h8, "t3_wait8");
        redirect = 1'b1;
        redirect_pc = 64'h100;
        exp_q.delete();
        push_addr(64'h100, 2);
        push_data(64'h100, 2);
        tick();
        redirect = 1'b0;
        chk("t3_flushed_valid", 64'(instr_valid), 64'd0);
        chk("t3_wait_req", 64'(mem_req), 64'd0);
        drain("t3");

        // 4: redirect while the request is held off by the memory
        do_reset();
        mem_stall = 1'b1;
        instr_ready = 1'b1;
        push_addr(64'h0, 1);
        wait_req("t4_req");
        redirect = 1'b1;
        redirect_pc = 64'h200;
        tick();
        redirect = 1'b0;
        chk("t4_addr_hold1", mem_addr, 64'h0);
        chk("t4_req_hold1", 64'(mem_req), 64'd1);
        tick();
        chk("t4_addr_hold2", mem_addr, 64'h0);
        chk("t4_req_hold2", 64'(mem_req), 64'd1);
        push_addr(64'h200, 2);
        push_data(64'h200, 2);
        tick();
        mem_stall = 1'b0;
        drain("t4");

        // 5: redirect coincides with rvalid, two entries queued
        do_reset();
        hold_en = 1'b1;
        hold_addr = 64'h8;
        push_addr(64'h0, 3);
        wait_pending(64'h8, "t5_wait8");
        chk("t5_head_pc", instr_pc, 64'h0);
        hold_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 64'h300;
        exp_q.delete();
        push_addr(64'h300, 2);
        push_data(64'h300, 2);
        tick();
        redirect = 1'b0;
        chk("t5_valid_flushed", 64'(instr_valid), 64'd0);
        chk("t5_req", 64'(mem_req), 64'd1);
        chk("t5_addr", mem_addr, 64'h300);
        instr_ready = 1'b1;
        drain("t5");

        // 6: reset during WAIT, stale response arrives after release
        do_reset();
        hold_en = 1'b1;
        hold_addr = 64'h0;
        instr_ready = 1'b1;
        push_addr(64'h0, 1);
        wait_pending(64'h0, "t6_wait0");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(instr_valid), 64'd0);
        chk("t6_rst_req", 64'(mem_req), 64'd0);
        chk("t6_rst_addr", mem_addr, RESET_PC);
        repeat (2) tick();
        rst_n = 1'b1;
        hold_en = 1'b0;
        push_addr(64'h0, 2);
        push_data(64'h0, 2);
        tick();
        chk("t6_spurious_ignored", 64'(instr_valid), 64'd0);
        chk("t6_req", 64'(mem_req), 64'd1);
        chk("t6_addr", mem_addr, RESET_PC);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
